// File: rtl/xgriscv_mem_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory-port arbiter.
package xgriscv_mem_arbiter_pkg;

    // Sequencer states: arbitrate, present request, wait for response/completion.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    // Which requester owns the transaction currently in flight.
    typedef enum logic {
        ARB_OWN_IF = 1'b0,
        ARB_OWN_D  = 1'b1
    } arb_owner_e;

    // Store width codes, same encoding as the controller's swhb field.
    localparam logic [1:0] MEM_SZ_B = 2'b01;
    localparam logic [1:0] MEM_SZ_H = 2'b10;
    localparam logic [1:0] MEM_SZ_W = 2'b11;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Saturating increment used by the starvation counter.
    function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic [3:0] limit);
        return (cnt >= limit) ? limit : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/xgriscv_mem_arbiter_if.sv
// Bundle of the pipeline-side request/response signals and the unified
// memory port. The arbiter uses the slave view; the surrounding pipeline
// and memory model use the master view.
interface xgriscv_mem_arbiter_if #(
    parameter int AW = 32
);
    // Instruction fetch requester
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;

    // Data (MEM stage) requester
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [1:0]    d_size;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;

    // Shared memory port
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [3:0]    m_be;
    logic [31:0]   m_wdata;
    logic          m_ready;
    logic          m_rvalid;
    logic [31:0]   m_rdata;

    // Pipeline stalls
    logic          stall_if;
    logic          stall_mem;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_size, d_wdata,
        input  m_ready, m_rvalid, m_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_addr, m_be, m_wdata,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_size, d_wdata,
        output m_ready, m_rvalid, m_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_addr, m_be, m_wdata,
        input  stall_if, stall_mem
    );

endinterface

// File: rtl/xgriscv_mem_arbiter_mem_be_gen.sv
// Byte-enable and write-lane generator for stores. Purely combinational:
// maps the store width code and the low address bits to byte enables and
// replicates the right-aligned store data across the lanes.
module mem_be_gen
    import xgriscv_mem_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  a,
    input  logic [31:0] wdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata_out
);

    // Decode width/alignment into lane enables and replicated data.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves it unassigned -- otherwise synthesis infers a latch.
        be        = BE_NONE;
        wdata_out = wdata_in;
        case (size)
            MEM_SZ_W: begin
                be = (a == 2'b00) ? BE_WORD : BE_NONE;
            end
            MEM_SZ_H: begin
                // A half on an odd byte cannot be expressed; it goes out with
                // no lanes enabled and completes as a no-op.
                be        = a[0] ? BE_NONE : (4'b0011 << {a[1], 1'b0});
                wdata_out = {2{wdata_in[15:0]}};
            end
            MEM_SZ_B: begin
                be        = 4'b0001 << a;
                wdata_out = {4{wdata_in[7:0]}};
            end
            default: begin
                be        = BE_NONE;
                wdata_out = wdata_in;
            end
        endcase
    end

endmodule

// File: rtl/xgriscv_mem_arbiter.sv
// Arbiter/sequencer for the single memory port shared by instruction fetch
// and the MEM stage. One transaction is in flight at a time; data normally
// wins arbitration, with a starvation guard that forces a fetch grant after
// STARVE_LIMIT consecutive data grants made while fetch was waiting.
module xgriscv_mem_arbiter
    import xgriscv_mem_arbiter_pkg::*;
#(
    parameter int AW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    xgriscv_mem_arbiter_if.slave  bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

    arb_state_e    state_q, state_d;
    arb_owner_e    owner_q, owner_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    starve_q, starve_d;

    logic          arb_en;
    logic          resp;
    logic          starve_block;
    logic          grant_d;
    logic          grant_if;
    logic          if_rvalid_w;
    logic          d_rvalid_w;
    logic [3:0]    gen_be;
    logic [31:0]   gen_wdata;

    mem_be_gen u_be_gen (
        .size      (bus.d_size),
        .a         (bus.d_addr[1:0]),
        .wdata_in  (bus.d_wdata),
        .be        (gen_be),
        .wdata_out (gen_wdata)
    );

    // Next-state, arbitration and latch-field selection.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        starve_d = starve_q;
        arb_en   = 1'b0;
        resp     = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                arb_en = 1'b1;
            end
            ARB_REQ: begin
                // Stores and reads both leave REQ on acceptance; a store's
                // completion is signalled from WAIT without waiting for m_rvalid.
                if (bus.m_ready) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                resp = we_q | bus.m_rvalid;
                if (resp) begin
                    state_d = ARB_IDLE;
                    arb_en  = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        // No grant can be taken while the state flops are held in reset.
        arb_en       = arb_en & reset;
        starve_block = bus.if_req && (starve_q == LIMIT);
        grant_d      = arb_en & bus.d_req & ~starve_block;
        grant_if     = arb_en & bus.if_req & ~grant_d;

        if (grant_d) begin
            state_d = ARB_REQ;
            owner_d = ARB_OWN_D;
            addr_d  = bus.d_addr & WORD_MASK;
            we_d    = bus.d_we;
            be_d    = bus.d_we ? gen_be : BE_WORD;
            wdata_d = bus.d_we ? gen_wdata : 32'h0;
            if (bus.if_req) begin
                starve_d = sat_inc(starve_q, LIMIT);
            end
        end else if (grant_if) begin
            state_d  = ARB_REQ;
            owner_d  = ARB_OWN_IF;
            addr_d   = bus.if_addr & WORD_MASK;
            we_d     = 1'b0;
            be_d     = BE_WORD;
            wdata_d  = 32'h0;
            starve_d = 4'd0;
        end
    end

    // State and latched transaction fields; async active-low reset aborts
    // any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            state_q  <= ARB_IDLE;
            owner_q  <= ARB_OWN_IF;
            addr_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= BE_NONE;
            wdata_q  <= 32'h0;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
        end
    end

    // Response routing: read data goes straight from the memory to the owner.
    assign if_rvalid_w = resp & (owner_q == ARB_OWN_IF);
    assign d_rvalid_w  = resp & (owner_q == ARB_OWN_D);

    assign bus.if_gnt    = grant_if;
    assign bus.d_gnt     = grant_d;
    assign bus.if_rvalid = if_rvalid_w;
    assign bus.d_rvalid  = d_rvalid_w;
    assign bus.if_rdata  = if_rvalid_w ? bus.m_rdata : 32'h0;
    assign bus.d_rdata   = (d_rvalid_w & ~we_q) ? bus.m_rdata : 32'h0;

    // Memory port is driven from registers only, so it holds steady until m_ready.
    assign bus.m_req   = (state_q == ARB_REQ);
    assign bus.m_we    = we_q;
    assign bus.m_addr  = addr_q;
    assign bus.m_be    = be_q;
    assign bus.m_wdata = wdata_q;

    // A requester stalls while asking, and while its transaction is in flight
    // up to (not including) the cycle its response arrives.
    assign bus.stall_if  = bus.if_req |
                           ((owner_q == ARB_OWN_IF) & (state_q != ARB_IDLE) & ~if_rvalid_w);
    assign bus.stall_mem = bus.d_req |
                           ((owner_q == ARB_OWN_D) & (state_q != ARB_IDLE) & ~d_rvalid_w);

endmodule

// File: tb/tb_xgriscv_mem_arbiter.sv
// Scoreboard bench for the IF/MEM memory arbiter: directed stimulus pushes
// expected grants, memory requests and responses into queues; monitors pop
// and compare whenever the DUT presents them.
module tb_xgriscv_mem_arbiter;
    import xgriscv_mem_arbiter_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_be;
    } mem_exp_t;

    typedef struct {
        arb_owner_e  owner;
        logic        is_store;
        logic [31:0] data;
    } rsp_exp_t;

    logic clk;
    logic reset;

    int n_total = 0;
    int n_pass  = 0;

    mem_exp_t   mem_q[$];
    rsp_exp_t   rsp_q[$];
    arb_owner_e gnt_q[$];

    int   ready_dly  = 0;
    int   rvalid_dly = 0;
    logic stray_req  = 1'b0;

    xgriscv_mem_arbiter_if #(.AW(32)) bus ();

    xgriscv_mem_arbiter #(.AW(32), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- helpers
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {16'hC0DE, addr[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic expect_load(input logic [31:0] addr, input arb_owner_e owner);
        mem_exp_t m;
        rsp_exp_t r;
        m.we = 1'b0; m.addr = addr & 32'hFFFF_FFFC; m.be = 4'b1111; m.wdata = 32'h0;
        m.chk_be = (owner == ARB_OWN_D);
        r.owner = owner; r.is_store = 1'b0; r.data = mem_word(addr & 32'hFFFF_FFFC);
        gnt_q.push_back(owner);
        mem_q.push_back(m);
        rsp_q.push_back(r);
    endtask

    task automatic expect_store(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
        mem_exp_t m;
        rsp_exp_t r;
        m.we = 1'b1; m.addr = addr & 32'hFFFF_FFFC; m.be = be; m.wdata = wdata; m.chk_be = 1'b1;
        r.owner = ARB_OWN_D; r.is_store = 1'b1; r.data = 32'h0;
        gnt_q.push_back(ARB_OWN_D);
        mem_q.push_back(m);
        rsp_q.push_back(r);
    endtask

    // Called at posedge+1; returns at posedge+1 after the grant with req low.
    task automatic issue_d(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] wdata);
        logic got;
        got = 1'b0;
        bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_size = size; bus.d_wdata = wdata;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.d_gnt) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("d_gnt_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.d_req = 1'b0;
    endtask

    task automatic issue_if(input logic [31:0] addr);
        logic got;
        got = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = addr;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.if_gnt) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("if_gnt_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (rsp_q.size() == 0 && mem_q.size() == 0 && gnt_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, {23'h0, bus.if_gnt, bus.if_rvalid, bus.d_gnt, bus.d_rvalid,
                              bus.m_req, bus.m_we, bus.stall_if, bus.stall_mem}, 32'h0);
        check({tag, "_m_addr"},   bus.m_addr, 32'h0);
        check({tag, "_m_be"},     {28'h0, bus.m_be}, 32'h0);
        check({tag, "_m_wdata"},  bus.m_wdata, 32'h0);
        check({tag, "_if_rdata"}, bus.if_rdata, 32'h0);
        check({tag, "_d_rdata"},  bus.d_rdata, 32'h0);
    endtask

    // ---------------------------------------------------------- memory model
    initial begin : mem_model
        int          req_cnt;
        int          rd_cnt;
        logic        rd_pending;
        logic [31:0] rd_data;
        req_cnt = 0; rd_cnt = 0; rd_pending = 1'b0; rd_data = 32'h0;
        forever begin
            @(posedge clk); #1;
            bus.m_ready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = 32'h0;
            if (!reset) begin
                rd_pending = 1'b0;
                req_cnt    = 0;
            end else if (stray_req) begin
                bus.m_rvalid = 1'b1;
                bus.m_rdata  = 32'hDEAD_BEEF;
                stray_req    = 1'b0;
            end else if (rd_pending) begin
                if (rd_cnt == 0) begin
                    bus.m_rvalid = 1'b1;
                    bus.m_rdata  = rd_data;
                    rd_pending   = 1'b0;
                end else begin
                    rd_cnt--;
                end
            end else if (bus.m_req) begin
                if (req_cnt == ready_dly) begin
                    bus.m_ready = 1'b1;
                    req_cnt     = 0;
                    if (!bus.m_we) begin
                        rd_pending = 1'b1;
                        rd_cnt     = rvalid_dly;
                        rd_data    = mem_word(bus.m_addr);
                    end
                end else begin
                    req_cnt++;
                end
            end
        end
    end

    // ---------------------------------------------------------------- monitor
    initial begin : monitor
        mem_exp_t   me;
        rsp_exp_t   re;
        arb_owner_e go;
        forever begin
            @(negedge clk);
            if (bus.if_gnt && bus.d_gnt) check("dual_gnt", 32'd1, 32'd0);
            if (bus.if_gnt || bus.d_gnt) begin
                if (gnt_q.size() == 0) begin
                    check("gnt_unexpected", 32'd1, 32'd0);
                end else begin
                    go = gnt_q.pop_front();
                    check("gnt_owner", 32'(bus.d_gnt), 32'(go));
                end
            end
            if (bus.m_req) begin
                if (mem_q.size() == 0) begin
                    check("m_req_unexpected", 32'd1, 32'd0);
                end else begin
                    me = mem_q[0];
                    check("m_addr", bus.m_addr, me.addr);
                    check("m_we", 32'(bus.m_we), 32'(me.we));
                    if (me.chk_be) check("m_be", 32'(bus.m_be), 32'(me.be));
                    if (me.we) check("m_wdata", bus.m_wdata, me.wdata);
                    if (bus.m_ready) void'(mem_q.pop_front());
                end
            end
            if (bus.if_rvalid || bus.d_rvalid) begin
                if (rsp_q.size() == 0) begin
                    check("rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    re = rsp_q.pop_front();
                    check("rsp_owner", 32'(bus.d_rvalid), 32'(re.owner));
                    if (!re.is_store) begin
                        check("rsp_data", bus.d_rvalid ? bus.d_rdata : bus.if_rdata, re.data);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------------------------------------------------------- stimulus
    initial begin : main
        reset = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_size = 2'b00; bus.d_wdata = 32'h0;
        bus.m_ready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("por");
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;

        // Simultaneous requests: data wins at cycle 0, fetch granted at cycle 2.
        expect_load(32'h100, ARB_OWN_D);
        expect_load(32'h40, ARB_OWN_IF);
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100; bus.d_size = MEM_SZ_W;
        @(negedge clk);
        check("sim_c0_gnts", {30'h0, bus.d_gnt, bus.if_gnt}, 32'h2);
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        @(negedge clk);
        check("sim_c1_m_req", 32'(bus.m_req), 32'd1);
        check("sim_c1_m_addr", bus.m_addr, 32'h100);
        @(negedge clk);
        check("sim_c2_d_rvalid", 32'(bus.d_rvalid), 32'd1);
        check("sim_c2_d_rdata", bus.d_rdata, 32'hC0DE_0100);
        check("sim_c2_if_gnt", 32'(bus.if_gnt), 32'd1);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
        drain();

        // Starvation guard: four data grants, then fetch, then the fifth data grant.
        for (int i = 0; i < 4; i++) expect_load(32'h300 + 32'(i) * 4, ARB_OWN_D);
        expect_load(32'h80, ARB_OWN_IF);
        expect_load(32'h310, ARB_OWN_D);
        fork
            issue_if(32'h80);
            begin
                for (int i = 0; i < 5; i++) issue_d(1'b0, 32'h300 + 32'(i) * 4, MEM_SZ_W, 32'h0);
            end
        join
        drain();

        // Stores: lane enables and replication, including misaligned no-ops.
        expect_store(32'h203, 4'b1000, 32'h5A5A_5A5A);
        issue_d(1'b1, 32'h203, MEM_SZ_B, 32'h1234_565A);
        expect_store(32'h202, 4'b1100, 32'h5678_5678);
        issue_d(1'b1, 32'h202, MEM_SZ_H, 32'hABCD_5678);
        expect_store(32'h201, 4'b0010, 32'h3C3C_3C3C);
        issue_d(1'b1, 32'h201, MEM_SZ_B, 32'h0000_003C);
        expect_store(32'h104, 4'b1111, 32'hCAFE_F00D);
        issue_d(1'b1, 32'h104, MEM_SZ_W, 32'hCAFE_F00D);
        expect_store(32'h101, 4'b0000, 32'hBEEF_BEEF);
        issue_d(1'b1, 32'h101, MEM_SZ_H, 32'h0000_BEEF);
        expect_store(32'h106, 4'b0000, 32'h1122_3344);
        issue_d(1'b1, 32'h106, MEM_SZ_W, 32'h1122_3344);
        drain();

        // Wait states: m_* held stable (monitor compares every cycle);
        // stall_if high until the if_rvalid cycle.
        ready_dly = 3; rvalid_dly = 2;
        expect_load(32'h44, ARB_OWN_IF);
        fork
            issue_if(32'h44);
        join_none
        begin : ws_loop
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (bus.if_rvalid) begin
                    check("ws_stall_if_drop", 32'(bus.stall_if), 32'd0);
                    seen = 1'b1;
                    break;
                end
                check("ws_stall_if_high", 32'(bus.stall_if), 32'd1);
            end
            if (!seen) check("ws_rvalid_timeout", 32'd0, 32'd1);
        end
        drain();
        ready_dly = 0; rvalid_dly = 0;

        // Reset in WAIT: outputs clear at once, stray m_rvalid is ignored,
        // the next request is served normally.
        rvalid_dly = 4;
        expect_load(32'h120, ARB_OWN_D);
        issue_d(1'b0, 32'h120, MEM_SZ_W, 32'h0);
        @(posedge clk); #2;
        check("rst_pre_stall_mem", 32'(bus.stall_mem), 32'd1);
        reset = 1'b0;
        rsp_q.delete();
        #1;
        check_outputs_zero("rst");
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        rvalid_dly = 0;
        stray_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stray_rvalid", {30'h0, bus.if_rvalid, bus.d_rvalid}, 32'h0);
        @(posedge clk); #1;
        expect_load(32'h124, ARB_OWN_D);
        issue_d(1'b0, 32'h124, MEM_SZ_W, 32'h0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
